mac_seq_ctrl: RTL and testbench

//  Sequencer for the 4x4 multiply-accumulate datapath. On a start command it clears the

---
 rtl/mac_seq_ctrl.sv | 111 +++++++++++
 tb/tb_mac_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl -- sequencer for the 4x4 multiply-accumulate datapath.
// A start pulse in IDLE clears the accumulator, latches the job length and
// accepts exactly len operand pairs over a valid/ready stream, summing a*b.
// The final sum is then held on a result handshake until the consumer takes it.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, len            job request (sampled only in IDLE) and pair count
//   busy                  high in RUN or DONE
//   in_valid/in_ready     operand stream handshake, in_a/in_b unsigned operands
//   res_valid/res_ready   result handshake, res_data sum, res_ovf sticky carry
//   count                 pairs accepted so far in the current job
module mac_seq_ctrl #(
   parameter int DW    = 4,
   parameter int ACC_W = 10,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_a,
   input  logic [DW-1:0]    in_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] res_data,
   output logic             res_ovf,
   output logic [CNT_W-1:0] count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc;
   logic             ovf;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] len_q;
   logic [2*DW-1:0]  prod;
   logic [ACC_W:0]   sum;
   logic             job_start;
   logic             accept;

   // Full-width product, zero-extended; the extra MSB of sum is the carry-out.
   assign prod = {{DW{1'b0}}, in_a} * {{DW{1'b0}}, in_b};
   assign sum  = {1'b0, acc} + (ACC_W+1)'(prod);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      job_start = 1'b0;
      accept    = 1'b0;
      busy      = 1'b0;
      in_ready  = 1'b0;
      res_valid = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               job_start = 1'b1;
               // A zero-length job skips RUN and reports the cleared sum.
               state_nxt = (len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            if (in_valid) begin
               accept = 1'b1;
               if (cnt == len_q - CNT_W'(1)) state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            // start is not looked at here, so a start coincident with the
            // result handshake is dropped.
            if (res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         ovf   <= 1'b0;
         cnt   <= '0;
         len_q <= '0;
      end else if (job_start) begin
         acc   <= '0;
         ovf   <= 1'b0;
         cnt   <= '0;
         len_q <= len;
      end else if (accept) begin
         acc   <= sum[ACC_W-1:0];
         ovf   <= ovf | sum[ACC_W];
         cnt   <= cnt + CNT_W'(1);
      end
   end

   // acc/ovf only change on start or accept, so they are stable through DONE.
   assign res_data = acc;
   assign res_ovf  = ovf;
   assign count    = cnt;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl -- self-checking bench for mac_seq_ctrl.
// Directed jobs from the block's test list plus randomized jobs (random
// lengths, operands, valid gaps, result back-pressure and stray start pulses).
// The reference is a plain sum of the accepted products: expected res_data is
// that sum mod 1024 and res_ovf is set when the unbounded sum reaches 1024.
module tb_mac_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] len;
   logic       busy;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic       res_valid;
   logic       res_ready;
   logic [9:0] res_data;
   logic       res_ovf;
   logic [3:0] count;

   int vectors    = 0;
   int miscompares = 0;

   int qa[$];
   int qb[$];
   int vq[$];   // optional forced in_valid pattern for the RUN phase

   mac_seq_ctrl #(.DW(4), .ACC_W(10), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_ovf(res_ovf), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      if (obs != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".busy"},      busy,      0);
      chk({tag, ".in_ready"},  in_ready,  0);
      chk({tag, ".res_valid"}, res_valid, 0);
      chk({tag, ".res_data"},  res_data,  0);
      chk({tag, ".res_ovf"},   res_ovf,   0);
      chk({tag, ".count"},     count,     0);
   endtask

   // One complete job: start in IDLE, feed qa/qb, hold result 'hold' cycles.
   // rnd_valid inserts random in_valid gaps (unless vq supplies a pattern).
   task automatic job(input int n, input bit rnd_valid, input int hold);
      int sum = 0;
      int acc_cnt = 0;
      int cyc = 0;
      int exp_data, exp_ovf;
      bit v;
      start = 1'b1; len = 4'(n);
      in_valid = 1'($urandom); in_a = 4'($urandom); in_b = 4'($urandom);
      step();
      start = 1'b0;
      chk("start.busy", busy, 1);
      while (acc_cnt < n && cyc < 200) begin
         chk("run.in_ready",  in_ready,  1);
         chk("run.res_valid", res_valid, 0);
         chk("run.count",     count,     acc_cnt);
         if (vq.size() > 0) v = 1'(vq.pop_front());
         else               v = rnd_valid ? 1'($urandom) : 1'b1;
         in_valid = v;
         in_a = 4'(qa[acc_cnt]);
         in_b = 4'(qb[acc_cnt]);
         // stray start with a different len must be ignored while busy
         start = 1'($urandom); len = 4'($urandom);
         step();
         if (v) begin
            sum += qa[acc_cnt] * qb[acc_cnt];
            acc_cnt++;
         end
         cyc++;
      end
      chk("run.timeout", int'(acc_cnt >= n), 1);
      exp_data = sum % 1024;
      exp_ovf  = (sum >= 1024) ? 1 : 0;
      res_ready = 1'b0;
      // pairs offered in DONE must not be consumed
      in_valid = 1'b1; in_a = 4'hF; in_b = 4'hF;
      for (int i = 0; i <= hold; i++) begin
         chk("done.res_valid", res_valid, 1);
         chk("done.in_ready",  in_ready,  0);
         chk("done.busy",      busy,      1);
         chk("done.res_data",  res_data,  exp_data);
         chk("done.res_ovf",   res_ovf,   exp_ovf);
         chk("done.count",     count,     n);
         if (i < hold) begin
            start = 1'($urandom); len = 4'($urandom);
            step();
         end
      end
      // handshake with a coincident start, which must be dropped
      res_ready = 1'b1; start = 1'b1; len = 4'($urandom_range(1, 15));
      step();
      res_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
      chk("idle.busy",      busy,      0);
      chk("idle.res_valid", res_valid, 0);
      chk("idle.in_ready",  in_ready,  0);
      chk("idle.count",     count,     n);
      step();
      chk("idle2.busy", busy, 0);
   endtask

   task automatic load(input int a[$], input int b[$]);
      qa = a; qb = b;
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
      in_a = '0; in_b = '0; res_ready = 1'b0;
      step(); step();
      chk_reset_vals("reset");
      rst = 1'b0;
      step();

      // 1: three back-to-back pairs, 12+30+225 = 267
      load('{3, 5, 15}, '{4, 6, 15});
      job(3, 1'b0, 0);

      // 2: five (15,15) wraps to 101 with overflow; next job clears ovf
      load('{15, 15, 15, 15, 15}, '{15, 15, 15, 15, 15});
      job(5, 1'b0, 1);
      load('{2}, '{2});
      job(1, 1'b0, 0);

      // 3: zero-length job held for 10 cycles
      job(0, 1'b0, 10);

      // 4: valid pattern with gaps, 1+4+9+16 = 30
      load('{1, 2, 3, 4}, '{1, 2, 3, 4});
      vq = '{1, 0, 0, 1, 1, 0, 1};
      job(4, 1'b0, 2);

      // 5: reset after three accepts of a len=6 job
      start = 1'b1; len = 4'd6;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_a = 4'($urandom); in_b = 4'($urandom);
         step();
      end
      chk("abort.count", count, 3);
      rst = 1'b1; in_valid = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0;
      chk_reset_vals("abort");
      load('{7, 1}, '{7, 9});
      job(2, 1'b0, 0);

      // randomized jobs
      for (int j = 0; j < 30; j++) begin
         n = $urandom_range(0, 15);
         qa.delete(); qb.delete();
         for (int k = 0; k < n; k++) begin
            qa.push_back($urandom_range(0, 15));
            qb.push_back($urandom_range(0, 15));
         end
         // bias some jobs toward large operands to exercise wrap/ovf
         if (j % 3 == 0) for (int k = 0; k < n; k++) begin
            qa[k] = $urandom_range(10, 15);
            qb[k] = $urandom_range(10, 15);
         end
         job(n, 1'($urandom), $urandom_range(0, 5));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
